// File: rtl/wm8731_i2c_pkg.sv
// Shared types and constants for the WM8731 I2C write responder.
package wm8731_i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_HI,
        S_HI_ACK,
        S_LO,
        S_LO_ACK,
        S_IGNORE
    } state_t;

    localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

    localparam logic [6:0] R_LLINE  = 7'd0;
    localparam logic [6:0] R_RLINE  = 7'd1;
    localparam logic [6:0] R_LHP    = 7'd2;
    localparam logic [6:0] R_RHP    = 7'd3;
    localparam logic [6:0] R_APATH  = 7'd4;
    localparam logic [6:0] R_DPATH  = 7'd5;
    localparam logic [6:0] R_PWR    = 7'd6;
    localparam logic [6:0] R_IFACE  = 7'd7;
    localparam logic [6:0] R_SAMPLE = 7'd8;
    localparam logic [6:0] R_ACTIVE = 7'd9;
    localparam logic [6:0] R_RESET  = 7'd15;

    // A START/STOP seen in these states means a register write was cut short.
    function automatic logic frame_open(input state_t s);
        return !((s == S_IDLE) || (s == S_IGNORE));
    endfunction

endpackage

// File: rtl/wm8731_i2c_responder_sync.sv
// Bus input conditioning: synchronizers on SCL/SDA plus edge and START/STOP detection.
module i2c_bus_sync
    import wm8731_i2c_pkg::*;
#(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda_s
);

    logic [P_SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [P_SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                     scl_hist_q, scl_hist_d;
    logic                     sda_hist_q, sda_hist_d;
    logic                     scl_s;

    assign scl_s   = scl_sync_q[P_SYNC_STAGES-1];
    assign o_sda_s = sda_sync_q[P_SYNC_STAGES-1];

    // Shift each line through its synchronizer, keep one sample of history.
    always_comb begin
        scl_sync_d = {scl_sync_q[P_SYNC_STAGES-2:0], i_scl};
        sda_sync_d = {sda_sync_q[P_SYNC_STAGES-2:0], i_sda};
        scl_hist_d = scl_s;
        sda_hist_d = o_sda_s;
    end

    // Reset to the idle-bus level so releasing reset never fabricates an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    // SCL must be high in both samples, so SDA moving alongside an SCL edge is data, not a condition.
    always_comb begin
        o_scl_rise = scl_s & ~scl_hist_q;
        o_scl_fall = ~scl_s & scl_hist_q;
        o_start    = scl_s & scl_hist_q & sda_hist_q & ~o_sda_s;
        o_stop     = scl_s & scl_hist_q & ~sda_hist_q & o_sda_s;
    end

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 end of the configuration bus: ACKs 3-byte register writes and emits the decoded write.
//
// state      | meaning
// S_IDLE     | bus free, waiting for START
// S_ADDR     | shifting in device address byte
// S_ADDR_ACK | driving ACK for address byte
// S_HI       | shifting in reg address + data bit 8
// S_HI_ACK   | driving ACK for high byte
// S_LO       | shifting in data bits 7:0
// S_LO_ACK   | driving ACK for low byte; write issued on release
// S_IGNORE   | frame done or not ours; NACK everything until START/STOP
module wm8731_i2c_responder
    import wm8731_i2c_pkg::*;
#(
    parameter logic [6:0] P_DEV_ADDR    = WM8731_DEV_ADDR,
    parameter int         P_SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_busy,
    output logic       o_frame_err
);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_bus_sync #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (start),
        .o_stop     (stop),
        .o_sda_s    (sda_s)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic [6:0] stage_addr_q, stage_addr_d;
    logic       stage_d8_q, stage_d8_d;
    logic [7:0] stage_lo_q, stage_lo_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic [8:0] reg_data_q, reg_data_d;

    logic       shifting;
    assign shifting = (state_q == S_ADDR) || (state_q == S_HI) || (state_q == S_LO);

    // Next-state logic; bus conditions take priority over SCL edges.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_done_d  = byte_done_q;
        stage_addr_d = stage_addr_q;
        stage_d8_d   = stage_d8_q;
        stage_lo_d   = stage_lo_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        wr_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_data_d   = reg_data_q;

        if (stop) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            sda_oe_d    = 1'b0;
            frame_err_d = frame_open(state_q);
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
        end else if (start) begin
            state_d     = S_ADDR;
            busy_d      = 1'b1;
            sda_oe_d    = 1'b0;
            frame_err_d = frame_open(state_q);
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
        end else if (scl_rise) begin
            if (shifting && !byte_done_q) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_d = 1'b1;
                end
            end
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR: begin
                    if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (shift_q == {P_DEV_ADDR, 1'b0}) begin
                            sda_oe_d = 1'b1;
                            state_d  = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_HI: begin
                    if (byte_done_q) begin
                        byte_done_d  = 1'b0;
                        stage_addr_d = shift_q[7:1];
                        stage_d8_d   = shift_q[0];
                        sda_oe_d     = 1'b1;
                        state_d      = S_HI_ACK;
                    end
                end
                S_LO: begin
                    if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        stage_lo_d  = shift_q;
                        sda_oe_d    = 1'b1;
                        state_d     = S_LO_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    state_d   = S_HI;
                end
                S_HI_ACK: begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    state_d   = S_LO;
                end
                S_LO_ACK: begin
                    sda_oe_d   = 1'b0;
                    wr_valid_d = 1'b1;
                    reg_addr_d = stage_addr_q;
                    reg_data_d = {stage_d8_q, stage_lo_q};
                    state_d    = S_IGNORE;
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; reset drops SDA drive without waiting for a clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_done_q  <= 1'b0;
            stage_addr_q <= 7'd0;
            stage_d8_q   <= 1'b0;
            stage_lo_q   <= 8'd0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            reg_addr_q   <= 7'd0;
            reg_data_q   <= 9'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_done_q  <= byte_done_d;
            stage_addr_q <= stage_addr_d;
            stage_d8_q   <= stage_d8_d;
            stage_lo_q   <= stage_lo_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_valid_q   <= wr_valid_d;
            frame_err_q  <= frame_err_d;
            reg_addr_q   <= reg_addr_d;
            reg_data_q   <= reg_data_d;
        end
    end

    assign o_sda_oe    = sda_oe_q;
    assign o_wr_valid  = wr_valid_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_data  = reg_data_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Bench for the WM8731 I2C responder: bit-level I2C master, write scoreboard, error-pulse counting.
module tb_wm8731_i2c_responder;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy;
    logic       frame_err;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    wm8731_i2c_responder #(
        .P_DEV_ADDR    (7'h1A),
        .P_SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_scl       (scl_m),
        .i_sda       (sda_bus),
        .o_sda_oe    (sda_oe),
        .o_wr_valid  (wr_valid),
        .o_reg_addr  (reg_addr),
        .o_reg_data  (reg_data),
        .o_busy      (busy),
        .o_frame_err (frame_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          err_cnt  = 0;
    logic [15:0] sb[$];
    logic [15:0] sb_exp;

    // Scoreboard: each write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", reg_addr, reg_data);
            end else begin
                sb_exp = sb.pop_front();
                if ({reg_addr, reg_data} !== sb_exp) begin
                    n_fail++;
                    $display("FAIL wr_decode: got addr=%h data=%h, required addr=%h data=%h",
                             reg_addr, reg_data, sb_exp[15:9], sb_exp[8:0]);
                end
            end
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_q(1);
        scl_m = 1'b1;
        wait_q(1);
        sda_m = 1'b0;
        wait_q(1);
        scl_m = 1'b0;
        wait_q(1);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q(1);
        scl_m = 1'b1;
        wait_q(1);
        sda_m = 1'b1;
        wait_q(2);
    endtask

    // Sends one byte MSB first and compares the ACK slot; optionally pulses reset inside the ACK clock.
    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input logic rst_in_ack);
        logic ack;
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            wait_q(1);
            scl_m = 1'b1;
            wait_q(2);
            scl_m = 1'b0;
            wait_q(1);
        end
        sda_m = 1'b1;
        wait_q(1);
        scl_m = 1'b1;
        wait_q(1);
        ack = ~sda_bus;
        n_checks++;
        if (ack !== exp_ack) begin
            n_fail++;
            $display("FAIL ack_slot byte=%h: got ack=%b, required ack=%b", b, ack, exp_ack);
        end
        if (rst_in_ack) begin
            #3 rst_n = 1'b0;
            #1;
            n_checks++;
            if ({sda_oe, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL async_reset: got sda_oe=%b busy=%b, required 0 0", sda_oe, busy);
            end
            @(negedge clk);
            rst_n = 1'b1;
        end
        wait_q(1);
        scl_m = 1'b0;
        wait_q(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({sda_oe, wr_valid, reg_addr, reg_data, busy, frame_err} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got oe=%b wv=%b a=%h d=%h busy=%b err=%b, required all 0",
                     sda_oe, wr_valid, reg_addr, reg_data, busy, frame_err);
        end
        rst_n = 1'b1;
        wait_q(2);
    endtask

    task automatic test_basic_write();
        int wr0 = wr_cnt;
        int er0 = err_cnt;
        sb.push_back({7'h0F, 9'h000});
        i2c_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b, required 1", busy);
        end
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h1E, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        i2c_stop();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_stop: got %b, required 0", busy);
        end
        n_checks++;
        if ((wr_cnt - wr0) != 1 || (err_cnt - er0) != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_counts: got writes=%0d errs=%0d pending=%0d, required 1 0 0",
                     wr_cnt - wr0, err_cnt - er0, sb.size());
        end
    endtask

    task automatic test_d8_and_restart();
        int wr0 = wr_cnt;
        int er0 = err_cnt;
        sb.push_back({7'h09, 9'h1FF});
        sb.push_back({7'h04, 9'h015});
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h13, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h08, 1'b1, 1'b0);
        send_byte(8'h15, 1'b1, 1'b0);
        i2c_stop();
        n_checks++;
        if (reg_addr !== 7'h04 || reg_data !== 9'h015) begin
            n_fail++;
            $display("FAIL held_outputs: got addr=%h data=%h, required 04 015", reg_addr, reg_data);
        end
        n_checks++;
        if ((wr_cnt - wr0) != 2 || (err_cnt - er0) != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL d8_counts: got writes=%0d errs=%0d pending=%0d, required 2 0 0",
                     wr_cnt - wr0, err_cnt - er0, sb.size());
        end
    endtask

    task automatic test_wrong_addr();
        int wr0 = wr_cnt;
        int er0 = err_cnt;
        logic [7:0] addrs [2];
        addrs[0] = 8'h36;
        addrs[1] = 8'h35;
        for (int k = 0; k < 2; k++) begin
            i2c_start();
            send_byte(addrs[k], 1'b0, 1'b0);
            send_byte(8'h1E, 1'b0, 1'b0);
            send_byte(8'h00, 1'b0, 1'b0);
            i2c_stop();
        end
        n_checks++;
        if ((wr_cnt - wr0) != 0 || (err_cnt - er0) != 0) begin
            n_fail++;
            $display("FAIL wrong_addr_counts: got writes=%0d errs=%0d, required 0 0",
                     wr_cnt - wr0, err_cnt - er0);
        end
    endtask

    task automatic test_frame_err();
        int wr0 = wr_cnt;
        int er0 = err_cnt;
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        i2c_stop();
        n_checks++;
        if ((wr_cnt - wr0) != 0 || (err_cnt - er0) != 1) begin
            n_fail++;
            $display("FAIL short_frame: got writes=%0d errs=%0d, required 0 1", wr_cnt - wr0, err_cnt - er0);
        end
        wr0 = wr_cnt;
        er0 = err_cnt;
        sb.push_back({7'h04, 9'h015});
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h08, 1'b1, 1'b0);
        send_byte(8'h15, 1'b1, 1'b0);
        i2c_stop();
        n_checks++;
        if ((wr_cnt - wr0) != 1 || (err_cnt - er0) != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL restart_abort: got writes=%0d errs=%0d pending=%0d, required 1 1 0",
                     wr_cnt - wr0, err_cnt - er0, sb.size());
        end
    endtask

    task automatic test_extra_byte();
        int wr0 = wr_cnt;
        int er0 = err_cnt;
        sb.push_back({7'h0F, 9'h000});
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h1E, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        i2c_stop();
        n_checks++;
        if ((wr_cnt - wr0) != 1 || (err_cnt - er0) != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL extra_byte: got writes=%0d errs=%0d pending=%0d, required 1 0 0",
                     wr_cnt - wr0, err_cnt - er0, sb.size());
        end
    endtask

    task automatic test_reset_mid_ack();
        int wr0 = wr_cnt;
        int er0 = err_cnt;
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h1E, 1'b1, 1'b1);
        i2c_stop();
        sb.push_back({7'h07, 9'h042});
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h0E, 1'b1, 1'b0);
        send_byte(8'h42, 1'b1, 1'b0);
        i2c_stop();
        n_checks++;
        if ((wr_cnt - wr0) != 1 || (err_cnt - er0) != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_frame: got writes=%0d errs=%0d pending=%0d, required 1 0 0",
                     wr_cnt - wr0, err_cnt - er0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_d8_and_restart();
        test_wrong_addr();
        test_frame_err();
        test_extra_byte();
        test_reset_mid_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
